// File: rtl/prio_enc_pkg.sv
// Shared definitions for the registered priority encoder: index-width derivation,
// legal request-width limits and the output-register state encoding.
package prio_enc_pkg;

  localparam int REQW_MIN = 2;
  localparam int REQW_MAX = 64;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic int binw_f(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational lowest-set-index finder: req -> (bin, hit). bin is 0 when no bit is set.
module prio_enc_core
  import prio_enc_pkg::*;
#(
  parameter int REQW = 8,
  parameter int BINW = 3
) (
  input  logic [REQW-1:0] req,
  output logic [BINW-1:0] bin,
  output logic            hit
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    bin = '0;
    hit = |req;
    for (int i = REQW - 1; i >= 0; i--) begin
      if (req[i]) bin = BINW'(i);
    end
  end

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered fixed/round-robin priority encoder with valid/ready on both sides.
// Round-robin search and its pointer exist only when RR_PRIO_ENC_RR_EN is defined.
module rr_priority_encoder
  import prio_enc_pkg::*;
#(
  parameter  int REQW = 8,
  localparam int BINW = binw_f(REQW)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [REQW-1:0] req,
  input  logic            rr_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BINW-1:0] bin,
  output logic [REQW-1:0] grant,
  output logic            hit
);

  state_e            state_q, state_d;
  logic [BINW-1:0]   bin_q, bin_d;
  logic [REQW-1:0]   grant_q, grant_d;
  logic              hit_q, hit_d;
  logic              accept;
  logic [BINW-1:0]   fx_bin, sel_bin;
  logic              fx_hit;

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign bin       = bin_q;
  assign grant     = grant_q;
  assign hit       = hit_q;

  prio_enc_core #(.REQW(REQW), .BINW(BINW)) u_core_fx (
    .req (req),
    .bin (fx_bin),
    .hit (fx_hit)
  );

`ifdef RR_PRIO_ENC_RR_EN
  logic [BINW-1:0] ptr_q, ptr_d;
  logic [REQW-1:0] ge_mask;
  logic [BINW-1:0] mk_bin;
  logic            mk_hit;
  logic [BINW:0]   ptr_inc;

  always_comb begin
    ge_mask = '0;
    for (int i = 0; i < REQW; i++) begin
      ge_mask[i] = (i >= int'(ptr_q));
    end
  end

  prio_enc_core #(.REQW(REQW), .BINW(BINW)) u_core_mk (
    .req (req & ge_mask),
    .bin (mk_bin),
    .hit (mk_hit)
  );

  // Fall back to the unmasked search when nothing sits at or above ptr (wrap-around).
  assign sel_bin = (rr_mode && mk_hit) ? mk_bin : fx_bin;
  assign ptr_inc = {1'b0, sel_bin} + (BINW+1)'(1);

  always_comb begin
    ptr_d = ptr_q;
    if (accept && fx_hit && rr_mode) begin
      ptr_d = (ptr_inc >= (BINW+1)'(REQW)) ? '0 : ptr_inc[BINW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  logic unused_rr_mode;
  assign unused_rr_mode = rr_mode;
  assign sel_bin        = fx_bin;
`endif

  always_comb begin
    state_d = EMPTY;
    bin_d   = bin_q;
    grant_d = grant_q;
    hit_d   = hit_q;
    if (accept) begin
      state_d = FULL;
      bin_d   = sel_bin;
      hit_d   = fx_hit;
      grant_d = '0;
      if (fx_hit) grant_d[sel_bin] = 1'b1;
    end else if (out_valid && !out_ready) begin
      state_d = FULL;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      bin_q   <= '0;
      grant_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      grant_q <= grant_d;
      hit_q   <= hit_d;
    end
  end

endmodule

// File: doc/rr_priority_encoder.md
# rr_priority_encoder

Registered, parametrised successor to the combinational first-one encoder: converts an REQW-bit request vector into the binary index and one-hot grant of the selected bit. Selection is fixed-priority (lowest index first) or round-robin, chosen at run time. It sits between the game-object collision/request logic (alien hits, bullet slots) and the consumers that service one object per transaction. A valid/ready handshake on both sides allows back-pressure.

## Interface
- REQW, 8, request vector width; legal range 2..64
- BINW, max(1,$clog2(REQW)), index width; derived, not overridden
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request vector valid
- in_ready  out  1  block can accept a vector this cycle
- req  in  REQW  request vector, any number of bits set
- rr_mode  in  1  0 = fixed lowest-index priority, 1 = round-robin; sampled with req
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result this cycle
- bin  out  BINW  selected index
- grant  out  REQW  one-hot of bin; all zero when hit = 0
- hit  out  1  at least one request bit was set

## Operation
- Accept when in_valid && in_ready; in_ready = !out_valid || out_ready (one-entry output register, full throughput).
- States: EMPTY (out_valid = 0), FULL (out_valid = 1). EMPTY→FULL on accept; FULL→EMPTY on out_ready without accept; FULL→FULL on out_ready with accept (result replaced same edge); FULL holds all outputs stable while out_ready = 0.
- Fixed mode: bin = lowest set index of req.
- Round-robin mode: search starts at ptr; bin = lowest set index ≥ ptr in req, else lowest set index overall (wrap-around).
- ptr (BINW bits, internal): on accept with hit = 1 and rr_mode = 1, ptr ← bin + 1, wrapping to 0 when bin = REQW−1. Fixed-mode accepts and zero-request accepts leave ptr unchanged.
- req all zero: accepted normally, out_valid = 1, hit = 0, bin = 0, grant = 0.
- Non-power-of-two REQW: ptr never exceeds REQW−1; index arithmetic is done in BINW+1 bits before the wrap compare.

## Timing
- Latency: accept on edge N → out_valid, bin, grant, hit valid after edge N (visible in cycle N+1).
- Throughput: one result per cycle while out_ready = 1.
- Reset: out_valid = 0, bin = 0, grant = 0, hit = 0, ptr = 0; in_ready = 1 in the cycle after rst deasserts. rst asserted mid-transaction discards the held result; no result is delivered after reset.
- rst dominates all simultaneous events.
- in_ready is combinational from out_valid/out_ready only; no combinational path from req to any output.

## Configuration
- RR_PRIO_ENC_RR_EN defined: round-robin search logic and ptr compiled in; rr_mode honoured.
- Not defined: ptr and the masked search are removed; rr_mode is ignored and the block is fixed-priority only, with identical handshake and timing.

## Structure
- Package prio_enc_pkg: BINW derivation function (max(1,$clog2(n))), REQW limits as constants, state encoding EMPTY/FULL.
- Sub-module prio_enc_core: combinational lowest-set-index finder (req → bin, hit), instantiated twice in round-robin builds (masked req ≥ ptr, and unmasked) and once otherwise; the top selects masked result when its hit = 1.

## Test plan
- Reset then fixed mode, REQW = 8, req = 8'b0010_1100, out_ready = 1 → next cycle bin = 2, grant = 8'h04, hit = 1.
- Round-robin, req = 8'hFF held for 10 accepts → bin sequence 0,1,…,7,0,1; ptr wraps after 7.
- Round-robin, ptr = 5 (after granting 4), req = 8'b0000_1001 → bin = 0 (wrap), then ptr = 1; next req 8'b0000_1001 → bin = 3.
- Back-pressure: out_ready = 0 for 4 cycles with in_valid = 1 → in_ready = 0, outputs stable, second vector accepted the cycle out_ready = 1, no loss or duplication.
- req = 0 → out_valid = 1, hit = 0, bin = 0, grant = 0, ptr unchanged; rst pulse while FULL → out_valid = 0 next cycle, ptr = 0.
- REQW = 5, round-robin, req = 5'b10001 repeated → bin 0,4,0,4; build without RR_PRIO_ENC_RR_EN → bin always 0.
